// File: rtl/wishbone_burst_ram_pkg.sv
// wishbone_burst_ram_pkg: Wishbone B4 cycle/burst type constants and the slave FSM state encoding.
package wishbone_burst_ram_pkg;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;
    localparam logic [1:0] BTE_LINEAR  = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLASSIC,
        ST_BURST,
        ST_ERROR
    } state_e;

endpackage

// File: rtl/wb_ram_1r1w_be.sv
// wb_ram_1r1w_be: byte-enabled simple dual-port RAM, registered read, no reset on data (block RAM template).
module wb_ram_1r1w_be #(
    parameter int DEPTH = 1024,
    parameter int NB    = 2,
    parameter int IW    = 10
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [NB-1:0]   be_i,
    input  logic [IW-1:0]   waddr_i,
    input  logic [8*NB-1:0] wdata_i,
    input  logic [IW-1:0]   raddr_i,
    output logic [8*NB-1:0] rdata_o
);

    logic [8*NB-1:0] mem_q [DEPTH];
    logic [8*NB-1:0] rdata_q;

    // Read-during-write to the same word returns the old contents.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB; b++)
            if (we_i && be_i[b]) mem_q[waddr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wishbone_burst_ram.sv
// wishbone_burst_ram: Wishbone B4 RAM slave with byte lanes, zero-wait linear bursts and
// err termination for addresses outside [BASE_ADDRESS, BASE_ADDRESS+MEMORY_SIZE).
module wishbone_burst_ram
    import wishbone_burst_ram_pkg::*;
#(
    parameter int                      ADDRESS_WIDTH = 16,
    parameter int                      DATA_BYTES    = 2,
    parameter logic [ADDRESS_WIDTH-1:0] BASE_ADDRESS = '0,
    parameter int                      MEMORY_SIZE   = 1024
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [ADDRESS_WIDTH-1:0]  adr_i,
    input  logic [8*DATA_BYTES-1:0]   dat_i,
    output logic [8*DATA_BYTES-1:0]   dat_o,
    input  logic                      we_i,
    input  logic [DATA_BYTES-1:0]     sel_i,
    input  logic                      stb_i,
    input  logic                      cyc_i,
    input  logic [2:0]                cti_i,
    input  logic [1:0]                bte_i,
    output logic                      ack_o,
    output logic                      err_o
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int IW = MEMORY_SIZE > 1 ? $clog2(MEMORY_SIZE) : 1;
    localparam logic [AW:0] MEM_END = (AW+1)'(MEMORY_SIZE);

    state_e         state_q, state_d;
    logic [AW:0]    cur_adr_q, cur_adr_d, nxt_adr;
    logic [AW-1:0]  loc_adr;
    logic [IW-1:0]  raddr;
    logic           req, valid, in_rng, ack, err, ram_we;

    assign loc_adr = adr_i - BASE_ADDRESS;
    assign req     = cyc_i & stb_i;
    assign valid   = {1'b0, loc_adr} < MEM_END;
    // cur_adr carries one extra bit so a burst can step one past the last word and be flagged.
    assign in_rng  = cur_adr_q < MEM_END;
    assign nxt_adr = cur_adr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        cur_adr_d = cur_adr_q;
        ack       = 1'b0;
        err       = 1'b0;
        ram_we    = 1'b0;
        raddr     = cur_adr_q[IW-1:0];
        case (state_q)
            ST_IDLE: if (req) begin
                cur_adr_d = {1'b0, loc_adr};
                raddr     = loc_adr[IW-1:0];
                state_d   = !valid ? ST_ERROR
                          : (cti_i == CTI_INCR && bte_i == BTE_LINEAR) ? ST_BURST : ST_CLASSIC;
            end
            ST_CLASSIC: begin
                ack     = 1'b1;
                ram_we  = we_i;
                state_d = ST_IDLE;
            end
            ST_ERROR: begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end
            ST_BURST: if (!cyc_i) begin
                state_d = ST_IDLE;
            end else if (stb_i && !in_rng) begin
                err     = 1'b1;
                state_d = ST_IDLE;
            end else if (stb_i) begin
                ack       = 1'b1;
                ram_we    = we_i;
                cur_adr_d = nxt_adr;
                raddr     = nxt_adr[IW-1:0];
                state_d   = cti_i == CTI_INCR ? ST_BURST : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cur_adr_q <= '0;
        end else begin
            state_q   <= state_d;
            cur_adr_q <= cur_adr_d;
        end
    end

    wb_ram_1r1w_be #(
        .DEPTH (MEMORY_SIZE),
        .NB    (DATA_BYTES),
        .IW    (IW)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (ram_we),
        .be_i    (sel_i),
        .waddr_i (cur_adr_q[IW-1:0]),
        .wdata_i (dat_i),
        .raddr_i (raddr),
        .rdata_o (dat_o)
    );

    assign ack_o = ack;
    assign err_o = err;

endmodule

// File: tb/tb_wishbone_burst_ram.sv
// tb_wishbone_burst_ram: randomized bus master checked against an array model of a 16-word RAM at 0x40.
module tb_wishbone_burst_ram;
    import wishbone_burst_ram_pkg::*;

    localparam int          MSZ  = 16;
    localparam logic [15:0] BASE = 16'h0040;

    logic        clk_i = 1'b0, rst_i = 1'b0;
    logic [15:0] adr_i, dat_i, dat_o;
    logic [1:0]  sel_i, bte_i;
    logic [2:0]  cti_i;
    logic        we_i, stb_i, cyc_i, ack_o, err_o;

    int checks = 0, errors = 0;
    logic [15:0] model [MSZ];

    wishbone_burst_ram #(
        .ADDRESS_WIDTH (16),
        .DATA_BYTES    (2),
        .BASE_ADDRESS  (BASE),
        .MEMORY_SIZE   (MSZ)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i), .adr_i (adr_i), .dat_i (dat_i), .dat_o (dat_o),
        .we_i (we_i), .sel_i (sel_i), .stb_i (stb_i), .cyc_i (cyc_i), .cti_i (cti_i),
        .bte_i (bte_i), .ack_o (ack_o), .err_o (err_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic int loc(input logic [15:0] a);
        return int'(16'(a - BASE));
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] s);
        return {s[1] ? d[15:8] : old[15:8], s[0] ? d[7:0] : old[7:0]};
    endfunction

    task automatic idle_bus();
        cyc_i = 0; stb_i = 0; we_i = 0; sel_i = 0;
        cti_i = CTI_CLASSIC; bte_i = BTE_LINEAR;
    endtask

    task automatic next_cycle();
        @(posedge clk_i); #1;
    endtask

    task automatic classic(input logic [15:0] a, input bit wr, input logic [15:0] d,
                           input logic [1:0] s, input logic [2:0] ct, input logic [1:0] bt, input string nm);
        bit ok;
        ok = loc(a) < MSZ;
        next_cycle();
        cyc_i = 1; stb_i = 1; we_i = wr; adr_i = a; dat_i = d; sel_i = s; cti_i = ct; bte_i = bt;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL %s_req ack=%b err=%b want ack=0 err=0", nm, ack_o, err_o);
        end
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (ack_o !== ok || err_o !== !ok) begin
            errors++; $display("FAIL %s_term adr=%h ack=%b err=%b want ack=%b err=%b", nm, a, ack_o, err_o, ok, !ok);
        end
        if (ok && !wr) begin
            checks++;
            if (dat_o !== model[loc(a)]) begin
                errors++; $display("FAIL %s_data adr=%h got=%h want=%h", nm, a, dat_o, model[loc(a)]);
            end
        end
        next_cycle();
        idle_bus();
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL %s_once ack=%b err=%b want ack=0 err=0", nm, ack_o, err_o);
        end
        if (ok && wr) model[loc(a)] = merge(model[loc(a)], d, s);
    endtask

    task automatic burst(input logic [15:0] a0, input int len, input bit wr,
                         input int st_at, input int st_n, input string nm);
        int l0;
        bit ok;
        logic [15:0] d;
        logic [1:0] s;
        l0 = loc(a0);
        next_cycle();
        cyc_i = 1; stb_i = 1; we_i = wr; adr_i = a0; dat_i = 16'($urandom); sel_i = 2'b11;
        cti_i = CTI_INCR; bte_i = BTE_LINEAR;
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL %s_req ack=%b err=%b want ack=0 err=0", nm, ack_o, err_o);
        end
        for (int k = 0; k < len; k++) begin
            if (k == st_at) for (int j = 0; j < st_n; j++) begin
                next_cycle();
                stb_i = 0;
                @(negedge clk_i);
                checks++;
                if (ack_o !== 1'b0 || err_o !== 1'b0) begin
                    errors++; $display("FAIL %s_stall ack=%b err=%b want ack=0 err=0", nm, ack_o, err_o);
                end
            end
            next_cycle();
            d = 16'($urandom); s = 2'($urandom);
            stb_i = 1; adr_i = a0 + 16'(k); dat_i = d; sel_i = s;
            cti_i = (k == len - 1) ? CTI_EOB : CTI_INCR;
            ok = (l0 + k) < MSZ;
            @(negedge clk_i);
            checks++;
            if (ack_o !== ok || err_o !== !ok) begin
                errors++; $display("FAIL %s_beat%0d ack=%b err=%b want ack=%b err=%b", nm, k, ack_o, err_o, ok, !ok);
            end
            if (!ok) break;
            if (!wr) begin
                checks++;
                if (dat_o !== model[l0+k]) begin
                    errors++; $display("FAIL %s_data%0d got=%h want=%h", nm, k, dat_o, model[l0+k]);
                end
            end else model[l0+k] = merge(model[l0+k], d, s);
        end
        next_cycle();
        idle_bus();
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL %s_end ack=%b err=%b want ack=0 err=0", nm, ack_o, err_o);
        end
    endtask

    task automatic check_all(input string nm);
        for (int i = 0; i < MSZ; i++) classic(BASE + 16'(i), 0, 16'h0, 2'b00, CTI_CLASSIC, BTE_LINEAR, nm);
    endtask

    task automatic test_reset();
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = BASE; dat_i = 16'hDEAD; sel_i = 2'b11;
        cti_i = CTI_CLASSIC; bte_i = BTE_LINEAR;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (ack_o !== 1'b0 || err_o !== 1'b0) begin
                errors++; $display("FAIL reset ack=%b err=%b want ack=0 err=0", ack_o, err_o);
            end
        end
        idle_bus();
        @(negedge clk_i);
        rst_i = 1;
        for (int i = 0; i < MSZ; i++) classic(BASE + 16'(i), 1, 16'($urandom), 2'b11, CTI_CLASSIC, BTE_LINEAR, "preload");
    endtask

    task automatic test_classic();
        classic(16'h0045, 1, 16'hBEEF, 2'b11, CTI_CLASSIC, BTE_LINEAR, "cl_wr");
        classic(16'h0045, 0, 16'h0, 2'b11, CTI_CLASSIC, BTE_LINEAR, "cl_rd");
        classic(16'h0046, 1, 16'hA5A5, 2'b11, CTI_INCR, 2'b01, "cl_bte");
        classic(16'h0046, 0, 16'h0, 2'b00, CTI_EOB, BTE_LINEAR, "cl_eob");
        for (int i = 0; i < 24; i++)
            classic(BASE - 16'd4 + 16'($urandom_range(0, 23)), 1'($urandom), 16'($urandom),
                    2'($urandom), $urandom_range(0, 1) ? CTI_CLASSIC : CTI_EOB, BTE_LINEAR, "cl_rnd");
    endtask

    task automatic test_byte_lanes();
        classic(16'h0045, 1, 16'hBEEF, 2'b11, CTI_CLASSIC, BTE_LINEAR, "bl_init");
        classic(16'h0045, 1, 16'h1234, 2'b01, CTI_CLASSIC, BTE_LINEAR, "bl_lo");
        classic(16'h0045, 0, 16'h0, 2'b00, CTI_CLASSIC, BTE_LINEAR, "bl_rd_lo");
        classic(16'h0045, 1, 16'h5678, 2'b10, CTI_CLASSIC, BTE_LINEAR, "bl_hi");
        classic(16'h0045, 1, 16'hFFFF, 2'b00, CTI_CLASSIC, BTE_LINEAR, "bl_none");
        classic(16'h0045, 0, 16'h0, 2'b11, CTI_CLASSIC, BTE_LINEAR, "bl_rd");
    endtask

    task automatic test_burst_read();
        for (int i = 0; i < 8; i++) classic(BASE + 16'(i), 1, 16'h0100 + 16'(i), 2'b11, CTI_CLASSIC, BTE_LINEAR, "bp_pre");
        burst(BASE, 4, 0, -1, 0, "br");
    endtask

    task automatic test_burst_stall();
        burst(BASE, 4, 0, 2, 2, "bs");
        burst(BASE + 16'd3, 5, 1, 1, 2, "bs_wr");
        burst(BASE + 16'd3, 5, 0, 3, 1, "bs_rd");
    endtask

    task automatic test_range_errors();
        classic(16'h003F, 0, 16'h0, 2'b11, CTI_CLASSIC, BTE_LINEAR, "re_lo");
        classic(16'h0050, 0, 16'h0, 2'b11, CTI_CLASSIC, BTE_LINEAR, "re_hi");
        classic(16'h0050, 1, 16'h1111, 2'b11, CTI_CLASSIC, BTE_LINEAR, "re_wr");
        burst(16'h004E, 3, 1, -1, 0, "re_bw");
        burst(16'h003F, 2, 0, -1, 0, "re_bstart");
        check_all("re_mem");
    endtask

    task automatic test_reset_mid_burst();
        logic [15:0] old;
        old = model[3];
        next_cycle();
        cyc_i = 1; stb_i = 1; we_i = 1; adr_i = BASE + 16'd3; dat_i = ~old; sel_i = 2'b11;
        cti_i = CTI_INCR; bte_i = BTE_LINEAR;
        next_cycle();
        @(negedge clk_i);
        checks++;
        if (ack_o !== 1'b1) begin
            errors++; $display("FAIL rmb_beat ack=%b want ack=1", ack_o);
        end
        #1 rst_i = 0;
        #1;
        checks++;
        if (ack_o !== 1'b0 || err_o !== 1'b0) begin
            errors++; $display("FAIL rmb_drop ack=%b err=%b want ack=0 err=0", ack_o, err_o);
        end
        next_cycle();
        idle_bus();
        @(negedge clk_i);
        rst_i = 1;
        classic(BASE + 16'd3, 0, 16'h0, 2'b11, CTI_CLASSIC, BTE_LINEAR, "rmb_rd");
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 20; i++) begin
            int len;
            len = $urandom_range(1, 6);
            burst(BASE + 16'($urandom_range(0, 16)), len, 1'($urandom),
                  $urandom_range(1, 5), $urandom_range(0, 2), "bb");
        end
        check_all("bb_mem");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_bus();
        adr_i = '0; dat_i = '0;
        test_reset();
        test_classic();
        test_byte_lanes();
        test_burst_read();
        test_burst_stall();
        test_range_errors();
        test_reset_mid_burst();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
